packet_retry_tx: RTL and testbench

PACKET_RETRY_TX -- requirements
Module: packet_retry_tx

---
 rtl/packet_pkg.sv | 26 ++
 rtl/packet_retry_tx_if.sv | 43 ++++
 rtl/packet_retry_tx.sv | 132 +++++++++++++
 tb/tb_packet_retry_tx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/packet_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : packet_pkg
//  Description : Shared state encoding, retry-counter width and helpers for
//                the packet retry transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package packet_pkg;

    localparam int c_STATE_W = 3;
    localparam int c_TRIES_W = 4;

    typedef enum logic [c_STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_WAIT = 3'd2,
        ST_REDO = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    function automatic logic [c_TRIES_W-1:0] f_sat_inc(input logic [c_TRIES_W-1:0] i_val);
        return (i_val == {c_TRIES_W{1'b1}}) ? i_val : i_val + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/packet_retry_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : packet_retry_tx_if
//  Description : Packet FIFO stream, link stream, far-end response and status
//                bundle for packet_retry_tx.
//  Revision    : 1.0 - initial release
// ============================================================================
interface packet_retry_tx_if
    import packet_pkg::*;
#(
    parameter int WIDTH = 8
) ();

    logic                 valid_i;
    logic                 ready_o;
    logic                 last_i;
    logic [WIDTH-1:0]     data_i;
    logic                 redo_o;
    logic                 next_o;
    logic                 valid_o;
    logic                 ready_i;
    logic                 last_o;
    logic [WIDTH-1:0]     data_o;
    logic                 ack_i;
    logic                 nak_i;
    logic                 busy_o;
    logic                 fail_o;
    logic [c_TRIES_W-1:0] tries_o;

    modport slave (
        input  valid_i, last_i, data_i, ready_i, ack_i, nak_i,
        output ready_o, redo_o, next_o, valid_o, last_o, data_o,
               busy_o, fail_o, tries_o
    );

    modport master (
        output valid_i, last_i, data_i, ready_i, ack_i, nak_i,
        input  ready_o, redo_o, next_o, valid_o, last_o, data_o,
               busy_o, fail_o, tries_o
    );

endinterface
`default_nettype wire

// File: rtl/packet_retry_tx.sv
`default_nettype none
// ============================================================================
//  Module      : packet_retry_tx
//  Description : Forwards one packet from the packet FIFO to the link, waits
//                for ack/nak and rewinds the FIFO for a resend on nak.
//                Optional ack timeout enabled by PACKET_RETRY_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module packet_retry_tx
    import packet_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 256
) (
    input wire               clock,
    input wire               reset,
    packet_retry_tx_if.slave bus
);

    if (WIDTH < 1 || MAX_RETRY < 1 || MAX_RETRY > 15 || TIMEOUT < 1) begin : g_bad_params
        $error("packet_retry_tx: illegal parameter value");
    end

    state_t               r_state;
    logic [c_TRIES_W-1:0] r_tries;
    logic                 r_redo;
    logic                 r_next;
    logic                 r_fail;
    logic                 r_busy;

    logic                 w_send;
    logic                 w_timeout;
    logic                 w_retry;
    logic [WIDTH-1:0]     w_data;

`ifdef PACKET_RETRY_TIMEOUT_EN
    localparam int c_TMR_W = $clog2(TIMEOUT + 1);

    logic [c_TMR_W-1:0] r_timer;

    // Runs only while waiting; any exit from WAIT restarts it from zero.
    always_ff @(posedge clock) begin
        if (reset || (r_state != ST_WAIT)) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    assign w_timeout = (r_state == ST_WAIT) && (r_timer == c_TMR_W'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    assign w_retry = bus.nak_i | w_timeout;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_tries <= '0;
            r_redo  <= 1'b0;
            r_next  <= 1'b0;
            r_fail  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_redo <= 1'b0;
            r_next <= 1'b0;
            r_fail <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.valid_i) begin
                        r_state <= ST_SEND;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (bus.valid_i && bus.ready_i && bus.last_i) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // ack has priority over nak/timeout
                    if (bus.ack_i) begin
                        r_state <= ST_DONE;
                        r_next  <= 1'b1;
                        r_tries <= '0;
                    end else if (w_retry) begin
                        if (r_tries < c_TRIES_W'(MAX_RETRY)) begin
                            r_state <= ST_REDO;
                            r_redo  <= 1'b1;
                            r_tries <= f_sat_inc(r_tries);
                        end else begin
                            r_state <= ST_DONE;
                            r_next  <= 1'b1;
                            r_fail  <= 1'b1;
                            r_tries <= '0;
                        end
                    end
                end
                ST_REDO: begin
                    r_state <= ST_SEND;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Reset gates every output so nothing leaks while reset is held.
    assign w_send      = (r_state == ST_SEND) && !reset;
    assign w_data      = bus.data_i;

    assign bus.valid_o = w_send & bus.valid_i;
    assign bus.ready_o = w_send & bus.ready_i;
    assign bus.last_o  = w_send & bus.last_i;
    assign bus.data_o  = w_send ? w_data : '0;

    assign bus.redo_o  = r_redo & ~reset;
    assign bus.next_o  = r_next & ~reset;
    assign bus.fail_o  = r_fail & ~reset;
    assign bus.busy_o  = r_busy & ~reset;
    assign bus.tries_o = reset ? '0 : r_tries;

endmodule
`default_nettype wire

// File: tb/tb_packet_retry_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_packet_retry_tx
//  Description : Self-checking bench for packet_retry_tx: per-cycle vector
//                table plus retry-exhaustion and timeout sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_packet_retry_tx;

    localparam int WIDTH     = 8;
    localparam int MAX_RETRY = 3;
    localparam int TIMEOUT   = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    packet_retry_tx_if #(.WIDTH(WIDTH)) bus ();

    packet_retry_tx #(
        .WIDTH     (WIDTH),
        .MAX_RETRY (MAX_RETRY),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // exp flags: {valid_o, ready_o, last_o, redo_o, next_o, busy_o, fail_o}
    typedef struct {
        logic       rst;
        logic       v;
        logic       r;
        logic       l;
        logic [7:0] d;
        logic       ack;
        logic       nak;
        logic [6:0] exp;
        logic [3:0] tries;
    } vec_t;

    vec_t       vecs[$];
    logic [8:0] sb[$];
    int         errors = 0;
    int         checks = 0;

    function automatic void add(input logic rst, v, r, l, input logic [7:0] d,
                                input logic ack, nak, input logic [6:0] exp,
                                input logic [3:0] tries);
        vec_t t;
        t.rst = rst; t.v = v; t.r = r; t.l = l; t.d = d;
        t.ack = ack; t.nak = nak; t.exp = exp; t.tries = tries;
        vecs.push_back(t);
    endfunction

    function automatic logic [10:0] outs();
        return {bus.valid_o, bus.ready_o, bus.last_o, bus.redo_o, bus.next_o,
                bus.busy_o, bus.fail_o, bus.tries_o};
    endfunction

    task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, v, r, l, input logic [7:0] d, input logic ack, nak);
        @(posedge clock);
        #1;
        reset       = rst;
        bus.valid_i = v;
        bus.ready_i = r;
        bus.last_i  = l;
        bus.data_i  = d;
        bus.ack_i   = ack;
        bus.nak_i   = nak;
    endtask

    // Link-side monitor: every accepted beat must match the next expected one.
    always @(negedge clock) begin
        if (bus.valid_o === 1'b1 && bus.ready_i === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_extra: got beat %h with nothing expected", {bus.last_o, bus.data_o});
            end else begin
                logic [8:0] e;
                e = sb.pop_front();
                if ({bus.last_o, bus.data_o} !== e) begin
                    errors++;
                    $display("FAIL sb_beat: got %h want %h", {bus.last_o, bus.data_o}, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nredo;
        int found;

        bus.valid_i = 1'b0; bus.ready_i = 1'b0; bus.last_i = 1'b0;
        bus.data_i  = '0;   bus.ack_i   = 1'b0; bus.nak_i  = 1'b0;

        // reset
        add(1,0,0,0,8'h00,0,0, 7'b0000000,0);
        add(1,1,1,1,8'hAA,1,1, 7'b0000000,0);
        // clean send, ack during SEND ignored, ack 3 cycles after last
        add(0,1,1,0,8'hAA,0,0, 7'b0000000,0);
        add(0,1,1,0,8'hAA,0,0, 7'b1100010,0);
        add(0,1,1,0,8'hBB,1,0, 7'b1100010,0);
        add(0,1,1,0,8'hCC,0,0, 7'b1100010,0);
        add(0,1,1,1,8'hDD,0,0, 7'b1110010,0);
        add(0,0,1,0,8'h00,0,0, 7'b0000010,0);
        add(0,0,1,0,8'h00,0,0, 7'b0000010,0);
        add(0,0,1,0,8'h00,1,0, 7'b0000010,0);
        add(0,0,1,0,8'h00,0,0, 7'b0000110,0);
        add(0,0,1,0,8'h00,0,0, 7'b0000000,0);
        // stalls, one nak, resend, ack
        add(0,1,1,0,8'h11,0,0, 7'b0000000,0);
        add(0,1,1,0,8'h11,0,0, 7'b1100010,0);
        add(0,0,1,0,8'h22,0,0, 7'b0100010,0);
        add(0,1,0,0,8'h22,0,0, 7'b1000010,0);
        add(0,1,1,0,8'h22,0,0, 7'b1100010,0);
        add(0,1,1,0,8'h33,0,0, 7'b1100010,0);
        add(0,1,1,1,8'h44,0,0, 7'b1110010,0);
        add(0,0,1,0,8'h00,0,1, 7'b0000010,0);
        add(0,1,1,0,8'h11,0,0, 7'b0001010,1);
        add(0,1,1,0,8'h11,0,0, 7'b1100010,1);
        add(0,1,1,0,8'h22,0,0, 7'b1100010,1);
        add(0,1,1,0,8'h33,0,0, 7'b1100010,1);
        add(0,1,1,1,8'h44,0,0, 7'b1110010,1);
        add(0,0,1,0,8'h00,0,0, 7'b0000010,1);
        add(0,0,1,0,8'h00,1,0, 7'b0000010,1);
        add(0,0,1,0,8'h00,0,0, 7'b0000110,0);
        add(0,0,1,0,8'h00,0,0, 7'b0000000,0);
        // single beat; nak in SEND ignored; ack+nak together in WAIT
        add(0,1,1,1,8'h55,0,0, 7'b0000000,0);
        add(0,1,1,1,8'h55,0,1, 7'b1110010,0);
        add(0,0,1,0,8'h00,1,1, 7'b0000010,0);
        add(0,0,1,0,8'h00,0,0, 7'b0000110,0);
        add(0,0,1,0,8'h00,0,0, 7'b0000000,0);
        // reset after beat 2 of 4, then full restart
        add(0,1,1,0,8'h66,0,0, 7'b0000000,0);
        add(0,1,1,0,8'h66,0,0, 7'b1100010,0);
        add(0,1,1,0,8'h77,0,0, 7'b1100010,0);
        add(1,1,1,0,8'h88,0,0, 7'b0000000,0);
        add(0,0,1,0,8'h00,0,0, 7'b0000000,0);
        add(0,1,1,0,8'h66,0,0, 7'b0000000,0);
        add(0,1,1,0,8'h66,0,0, 7'b1100010,0);
        add(0,1,1,0,8'h77,0,0, 7'b1100010,0);
        add(0,1,1,0,8'h88,0,0, 7'b1100010,0);
        add(0,1,1,1,8'h99,0,0, 7'b1110010,0);
        add(0,0,1,0,8'h00,1,0, 7'b0000010,0);
        add(0,0,1,0,8'h00,0,0, 7'b0000110,0);
        add(0,0,1,0,8'h00,0,0, 7'b0000000,0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].v, vecs[i].r, vecs[i].l, vecs[i].d, vecs[i].ack, vecs[i].nak);
            if (vecs[i].exp[6] && vecs[i].r && !vecs[i].rst)
                sb.push_back({vecs[i].l, vecs[i].d});
            @(negedge clock);
            chk($sformatf("vec%0d", i), outs(), {vecs[i].exp, vecs[i].tries});
        end

        // retry exhaustion: 4 naks -> 3 redo pulses, then fail with next
        nredo = 0;
        drive(0,1,1,0,8'hA0,0,0);
        @(negedge clock);
        for (int att = 0; att <= MAX_RETRY; att++) begin
            drive(0,1,1,0,8'hA0,0,0); sb.push_back({1'b0, 8'hA0});
            @(negedge clock); nredo += int'(bus.redo_o);
            drive(0,1,1,1,8'hA1,0,0); sb.push_back({1'b1, 8'hA1});
            @(negedge clock); nredo += int'(bus.redo_o);
            drive(0,0,1,0,8'h00,0,1);
            @(negedge clock); nredo += int'(bus.redo_o);
            drive(0,(att < MAX_RETRY),1,0,8'hA0,0,0);
            @(negedge clock); nredo += int'(bus.redo_o);
            if (att < MAX_RETRY)
                chk($sformatf("retry%0d", att), outs(), {7'b0001010, 4'(att + 1)});
            else
                chk("retry_fail", outs(), {7'b0000111, 4'd0});
        end
        drive(0,0,1,0,8'h00,0,0);
        @(negedge clock); nredo += int'(bus.redo_o);
        chk("retry_idle", outs(), 11'b0);
        chk("retry_redo_count", 11'(nredo), 11'd3);

`ifdef PACKET_RETRY_TIMEOUT_EN
        // no response: redo must fire TIMEOUT cycles after WAIT entry
        found = -1;
        drive(0,1,1,1,8'hC3,0,0);
        @(negedge clock);
        drive(0,1,1,1,8'hC3,0,0); sb.push_back({1'b1, 8'hC3});
        @(negedge clock);
        for (int n = 0; n < 40; n++) begin
            drive(0,0,1,0,8'h00,0,0);
            @(negedge clock);
            if (bus.redo_o === 1'b1) begin
                found = n;
                break;
            end
        end
        chk("timeout_delay", 11'(found), 11'(TIMEOUT));
        if (found >= 0) begin
            drive(0,1,1,1,8'hC3,0,0); sb.push_back({1'b1, 8'hC3});
            @(negedge clock);
            drive(0,0,1,0,8'h00,1,0);
            @(negedge clock);
            drive(0,0,1,0,8'h00,0,0);
            @(negedge clock);
            chk("timeout_done", outs(), {7'b0000110, 4'd0});
        end
`else
        found = 0;
`endif

        drive(1,0,0,0,8'h00,0,0);
        @(negedge clock);
        chk("final_reset", outs(), 11'b0);
        chk("sb_drain", 11'(sb.size()), 11'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
